// File: rtl/sync_pack_fifo_pkg.sv
// Shared helpers for sync_pack_fifo: width derivation functions and default geometry.
package sync_pack_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Lane counter needs at least one bit even when RATIO=1.
    function automatic int lane_w(input int ratio);
        return (clog2(ratio) > 0) ? clog2(ratio) : 1;
    endfunction

    function automatic int out_w(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int wr_lvl_w(input int depth_w, input int ratio);
        return depth_w + clog2(ratio) + 1;
    endfunction

    function automatic int rd_lvl_w(input int depth_w);
        return depth_w + 1;
    endfunction

    localparam int DEF_IN_W     = 32;
    localparam int DEF_RATIO    = 4;
    localparam int DEF_DEPTH_W  = 5;
    localparam int DEF_OUT_W    = out_w(DEF_IN_W, DEF_RATIO);
    localparam int DEF_WR_LVL_W = wr_lvl_w(DEF_DEPTH_W, DEF_RATIO);
    localparam int DEF_RD_LVL_W = rd_lvl_w(DEF_DEPTH_W);

endpackage

// File: rtl/sync_pack_fifo_ram.sv
// Simple dual-port storage for sync_pack_fifo: synchronous write, registered read port.
module sync_pack_fifo_ram #(
    parameter int W  = 128,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [0:(1<<AW)-1];
    logic [W-1:0] r_rdata;

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_pack_fifo.sv
// Single-clock FIFO packing RATIO narrow words into one wide word, with input-granular levels.
// Define SYNC_PACK_FIFO_FLUSH_EN to add wr_flush, which pushes a partial word zero-padded.
module sync_pack_fifo
    import sync_pack_fifo_pkg::*;
#(
    parameter int IN_W             = 32,
    parameter int RATIO            = 4,
    parameter int DEPTH_W          = 5,
    parameter int ALMOST_FULL_NUM  = 124,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [IN_W-1:0]                  wr_data,
`ifdef SYNC_PACK_FIFO_FLUSH_EN
    input  logic                             wr_flush,
`endif
    output logic                             wr_full,
    output logic                             almost_full,
    output logic [DEPTH_W+clog2(RATIO):0]    wr_water_level,
    input  logic                             rd_en,
    output logic [IN_W*RATIO-1:0]            rd_data,
    output logic                             rd_empty,
    output logic                             almost_empty,
    output logic [DEPTH_W:0]                 rd_water_level
);

    localparam int LW    = clog2(RATIO);
    localparam int LW_S  = lane_w(RATIO);
    localparam int OUT_W = out_w(IN_W, RATIO);
    localparam int DEPTH = 1 << DEPTH_W;
    localparam int WL    = wr_lvl_w(DEPTH_W, RATIO);
    localparam int CW    = rd_lvl_w(DEPTH_W);

    logic [LW_S-1:0]    r_lane_cnt;
    logic [OUT_W-1:0]   r_pack;
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_store_full;
    logic               w_last_lane;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_complete;
    logic               w_flush_push;
    logic               w_push;
    logic [OUT_W-1:0]   w_pack_next;
    logic [WL-1:0]      w_wr_lvl;

    assign w_store_full = (r_count == CW'(DEPTH));
    assign w_last_lane  = (r_lane_cnt == LW_S'(RATIO - 1));
    assign w_empty      = (r_count == '0);
    assign w_wr_acc     = wr_en && !w_full;
    assign w_rd_acc     = rd_en && !w_empty;
    assign w_complete   = w_wr_acc && w_last_lane;
    assign w_push       = w_complete || w_flush_push;

    // Unfilled upper lanes are already zero because r_pack clears on every push.
    always_comb begin
        w_pack_next = r_pack;
        if (w_wr_acc) begin
            w_pack_next[r_lane_cnt*IN_W +: IN_W] = wr_data;
        end
    end

`ifdef SYNC_PACK_FIFO_FLUSH_EN
    logic r_flush_pend;
    logic w_flush_req;
    logic w_has_partial;

    assign w_flush_req   = wr_flush || r_flush_pend;
    assign w_has_partial = !w_complete && (w_wr_acc || (r_lane_cnt != '0));
    assign w_flush_push  = w_flush_req && w_has_partial && !w_store_full;
    // A pending flush blocks writes so the partial word it owns cannot grow.
    assign w_full        = (w_store_full && w_last_lane) || r_flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush_req && w_has_partial && w_store_full;
        end
    end
`else
    assign w_flush_push = 1'b0;
    assign w_full       = w_store_full && w_last_lane;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_pack     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_lane_cnt <= '0;
                r_pack     <= '0;
            end else if (w_wr_acc) begin
                r_lane_cnt <= r_lane_cnt + 1'b1;
                r_pack     <= w_pack_next;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    sync_pack_fifo_ram #(
        .W  (OUT_W),
        .AW (DEPTH_W)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_pack_next),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    assign w_wr_lvl       = (WL'(r_count) << LW) | WL'(r_lane_cnt);
    assign wr_full        = w_full;
    assign almost_full    = (int'(w_wr_lvl) >= ALMOST_FULL_NUM);
    assign wr_water_level = w_wr_lvl;
    assign rd_empty       = w_empty;
    assign almost_empty   = (int'(r_count) <= ALMOST_EMPTY_NUM);
    assign rd_water_level = r_count;

endmodule

// File: tb/tb_sync_pack_fifo.sv
// Bench for sync_pack_fifo: queue-level model checked every cycle plus directed literal expectations.
module tb_sync_pack_fifo;

    localparam int IN_W    = 32;
    localparam int RATIO   = 4;
    localparam int DEPTH_W = 5;
    localparam int DEPTH   = 32;
    localparam int OUT_W   = 128;
    localparam int AF_NUM  = 124;
    localparam int AE_NUM  = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [IN_W-1:0]   wr_data;
    logic              flush_i;
    logic              wr_full;
    logic              almost_full;
    logic [7:0]        wr_water_level;
    logic              rd_en;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_empty;
    logic              almost_empty;
    logic [5:0]        rd_water_level;

    int n_checks;
    int n_fail;

    sync_pack_fifo #(
        .IN_W             (IN_W),
        .RATIO            (RATIO),
        .DEPTH_W          (DEPTH_W),
        .ALMOST_FULL_NUM  (AF_NUM),
        .ALMOST_EMPTY_NUM (AE_NUM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
`ifdef SYNC_PACK_FIFO_FLUSH_EN
        .wr_flush       (flush_i),
`endif
        .wr_full        (wr_full),
        .almost_full    (almost_full),
        .wr_water_level (wr_water_level),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .almost_empty   (almost_empty),
        .rd_water_level (rd_water_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_w(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: stored wide words and the lanes of the word being assembled.
    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  lane_q[$];
    logic [OUT_W-1:0] m_rd;
    bit               m_pend;
    bit               m_live;

    function automatic logic [OUT_W-1:0] pack_lanes();
        logic [OUT_W-1:0] w;
        w = '0;
        foreach (lane_q[k]) w[k*IN_W +: IN_W] = lane_q[k];
        return w;
    endfunction

    initial begin
        m_live = 1'b0;
        m_pend = 1'b0;
        m_rd   = '0;
    end

    always @(posedge clk) begin : model_blk
        bit m_full;
        bit rd_acc;
        bit wr_acc;
        bit done;
        int cnt0;
        if (rst) begin
            exp_q.delete();
            lane_q.delete();
            m_pend = 1'b0;
            m_rd   = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            cnt0   = exp_q.size();
            m_full = (cnt0 == DEPTH && lane_q.size() == RATIO - 1) || m_pend;
            rd_acc = rd_en && (cnt0 != 0);
            wr_acc = wr_en && !m_full;
            done   = 1'b0;
            if (rd_acc) m_rd = exp_q.pop_front();
            if (wr_acc) begin
                lane_q.push_back(wr_data);
                if (lane_q.size() == RATIO) begin
                    exp_q.push_back(pack_lanes());
                    lane_q.delete();
                    done = 1'b1;
                end
            end
            if ((flush_i || m_pend) && !done && lane_q.size() > 0) begin
                if (cnt0 < DEPTH) begin
                    exp_q.push_back(pack_lanes());
                    lane_q.delete();
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end else begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int lvl;
        if (m_live) begin
            lvl = exp_q.size() * RATIO + lane_q.size();
            check_w("rd_data", rd_data, m_rd);
            check_n("rd_empty", int'(rd_empty), int'(exp_q.size() == 0));
            check_n("rd_water_level", int'(rd_water_level), exp_q.size());
            check_n("almost_empty", int'(almost_empty), int'(exp_q.size() <= AE_NUM));
            check_n("wr_water_level", int'(wr_water_level), lvl);
            check_n("almost_full", int'(almost_full), int'(lvl >= AF_NUM));
            check_n("wr_full", int'(wr_full),
                    int'((exp_q.size() == DEPTH && lane_q.size() == RATIO - 1) || m_pend));
        end
    end

    task automatic step(input bit w, input logic [IN_W-1:0] d, input bit r, input bit f);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush_i = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_en    = 1'b0;
        flush_i  = 1'b0;
        idle();
        idle();
        rst = 1'b0;

        check_n("reset rd_empty", int'(rd_empty), 1);
        check_n("reset almost_empty", int'(almost_empty), 1);
        check_n("reset wr_full", int'(wr_full), 0);
        check_n("reset almost_full", int'(almost_full), 0);
        check_n("reset wr_level", int'(wr_water_level), 0);
        check_n("reset rd_level", int'(rd_water_level), 0);
        check_w("reset rd_data", rd_data, '0);

        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check_n("one word rd_empty", int'(rd_empty), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_w("first word", rd_data, 128'h00000003_00000002_00000001_00000000);
        check_n("drained rd_empty", int'(rd_empty), 1);

        for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h10 + i), 1'b0, 1'b0);
        check_n("partial wr_level", int'(wr_water_level), 3);
        check_n("partial rd_level", int'(rd_water_level), 0);
        check_n("partial rd_empty", int'(rd_empty), 1);
        step(1'b1, 32'h13, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_w("second word", rd_data, 128'h00000013_00000012_00000011_00000010);

        // Fill to the write-side limit: 32 stored words plus 3 packed lanes.
        for (int i = 0; i < 131; i++) begin
            step(1'b1, 32'(32'h1000 + i), 1'b0, 1'b0);
            if (i == 122) check_n("almost_full at 123", int'(almost_full), 0);
            if (i == 123) check_n("almost_full at 124", int'(almost_full), 1);
            if (i == 127) check_n("wr_full at 128", int'(wr_full), 0);
        end
        check_n("wr_full at 131", int'(wr_full), 1);
        check_n("wr_level at 131", int'(wr_water_level), 131);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check_n("dropped write level", int'(wr_water_level), 131);
        step(1'b1, 32'hBEEF, 1'b1, 1'b0);
        check_n("rd+wr on full rd_level", int'(rd_water_level), 31);
        check_n("rd+wr on full wr_level", int'(wr_water_level), 127);
        check_w("rd+wr on full data", rd_data, 128'h00001003_00001002_00001001_00001000);
        step(1'b1, 32'h2000, 1'b0, 1'b0);
        check_n("retry accepted level", int'(wr_water_level), 128);
        check_n("retry accepted full", int'(wr_full), 0);
        repeat (32) step(1'b0, '0, 1'b1, 1'b0);
        check_w("last drained word", rd_data, 128'h00002000_00001082_00001081_00001080);
        check_n("fully drained", int'(rd_empty), 1);

        for (int i = 0; i < 60; i++) step((i % 5) != 4, 32'(32'h3000 + i), (i % 3) == 2, 1'b0);
        repeat (20) step(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) step(1'b1, 32'(32'h4000 + i), 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 32'h4FFF, 1'b1, 1'b0);
        rst = 1'b0;
        check_n("mid reset wr_level", int'(wr_water_level), 0);
        check_n("mid reset rd_level", int'(rd_water_level), 0);
        check_n("mid reset rd_empty", int'(rd_empty), 1);
        check_w("mid reset rd_data", rd_data, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h5000 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_w("post reset word", rd_data, 128'h00005003_00005002_00005001_00005000);

`ifdef SYNC_PACK_FIFO_FLUSH_EN
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check_w("flush word", rd_data, 128'h00000000_00000000_0000000B_0000000A);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check_w("write+flush word", rd_data, 128'h00000000_00000000_00000000_0000000C);
        step(1'b0, '0, 1'b0, 1'b1);
        check_n("empty flush no-op", int'(rd_water_level), 0);

        for (int i = 0; i < 128; i++) step(1'b1, 32'(32'h6000 + i), 1'b0, 1'b0);
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        check_n("full storage partial wr_full", int'(wr_full), 0);
        step(1'b0, '0, 1'b0, 1'b1);
        check_n("pending flush wr_full", int'(wr_full), 1);
        step(1'b1, 32'hEE, 1'b0, 1'b0);
        check_n("pending write dropped", int'(wr_water_level), 130);
        step(1'b0, '0, 1'b1, 1'b0);
        check_n("pending after read", int'(wr_full), 1);
        idle();
        check_n("pending pushed level", int'(rd_water_level), 32);
        check_n("pending cleared", int'(wr_full), 0);
        repeat (32) step(1'b0, '0, 1'b1, 1'b0);
        check_w("pending flush word", rd_data, 128'h00000000_00000000_0000000B_0000000A);
`endif

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
